// File: rtl/seg7_pkg.sv
// Shared constants for the seven-segment scan capture: active-low glyph codes,
// idle bus values, FSM encoding and small anode-bus helpers.
package seg7_pkg;

  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  localparam logic [6:0] SEG_IDLE = 7'h7F;
  localparam logic [3:0] AN_IDLE  = 4'hF;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLING = 2'd1,
    CAPTURED = 2'd2
  } scan_state_e;

  function automatic logic [2:0] low_count(input logic [3:0] an);
    logic [2:0] n;
    n = 3'd0;
    for (int i = 0; i < 4; i++) begin
      n = n + {2'b00, ~an[i]};
    end
    return n;
  endfunction

  // Lowest-numbered active anode; only meaningful when exactly one is low.
  function automatic logic [1:0] low_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!an[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_glyph_decode.sv
// Active-low seven-segment pattern to hex nibble; hit_o is low for any pattern
// outside the 16-entry glyph table.
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg_i,
  output logic [3:0] nibble_o,
  output logic       hit_o
);

  always_comb begin
    nibble_o = 4'h0;
    hit_o    = 1'b1;
    case (seg_i)
      GLYPH_0: nibble_o = 4'h0;
      GLYPH_1: nibble_o = 4'h1;
      GLYPH_2: nibble_o = 4'h2;
      GLYPH_3: nibble_o = 4'h3;
      GLYPH_4: nibble_o = 4'h4;
      GLYPH_5: nibble_o = 4'h5;
      GLYPH_6: nibble_o = 4'h6;
      GLYPH_7: nibble_o = 4'h7;
      GLYPH_8: nibble_o = 4'h8;
      GLYPH_9: nibble_o = 4'h9;
      GLYPH_A: nibble_o = 4'hA;
      GLYPH_B: nibble_o = 4'hB;
      GLYPH_C: nibble_o = 4'hC;
      GLYPH_D: nibble_o = 4'hD;
      GLYPH_E: nibble_o = 4'hE;
      GLYPH_F: nibble_o = 4'hF;
      default: hit_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_scan_capture.sv
// Receiver for a multiplexed active-low seven-segment bus: waits for each digit to
// settle, decodes it back to hex and rebuilds the 4-digit word with valid/error flags.
//   state    | meaning
//   IDLE     | all anodes high, nothing to capture
//   SETTLING | sample present, waiting for SETTLE stable cycles
//   CAPTURED | current sample consumed, waiting for the bus to change
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int unsigned SETTLE = 4,
  parameter int unsigned CNT_W  = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [6:0]  seven,
  input  logic [3:0]  AN,
  output logic [15:0] digits,
  output logic [3:0]  digit_valid,
  output logic [3:0]  glyph_err,
  output logic        frame_done,
  output logic        bus_err
);

  localparam logic [10:0]      BUS_IDLE = {AN_IDLE, SEG_IDLE};
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(SETTLE);
  // Counter value on the edge that carries it to SETTLE-1; SETTLE=1 settles one edge after a change.
  localparam logic [CNT_W-1:0] CNT_GATE = (SETTLE >= 2) ? CNT_W'(SETTLE - 2) : '0;

  logic [10:0]      sync1_q, sync2_q, prev_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  scan_state_e      state_q, state_d;
  logic [15:0]      digits_q, digits_d;
  logic [3:0]       valid_q, valid_d;
  logic [3:0]       gerr_q, gerr_d;
  logic [3:0]       mask_q, mask_d;
  logic             frame_q, frame_d;
  logic             bus_err_q, bus_err_d;

  logic [3:0] s_an;
  logic [6:0] s_seg;
  logic       changed, settled, all_high, one_low;
  logic [1:0] cap_idx;
  logic [3:0] dec_nibble;
  logic       dec_hit;
  logic       capture;

  assign s_an     = sync2_q[10:7];
  assign s_seg    = sync2_q[6:0];
  assign changed  = (sync2_q != prev_q);
  assign settled  = !changed && (cnt_q == CNT_GATE);
  assign all_high = (s_an == AN_IDLE);
  assign one_low  = (low_count(s_an) == 3'd1);
  assign cap_idx  = low_index(s_an);

  seg7_glyph_decode u_decode (
    .seg_i    (s_seg),
    .nibble_o (dec_nibble),
    .hit_o    (dec_hit)
  );

  always_comb begin
    if (changed) begin
      cnt_d = '0;
    end else if (cnt_q >= CNT_MAX) begin
      cnt_d = cnt_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    state_d   = state_q;
    capture   = 1'b0;
    bus_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (!all_high) state_d = SETTLING;
      end
      SETTLING: begin
        if (all_high) begin
          state_d = IDLE;
        end else if (settled) begin
          state_d = CAPTURED;
          if (one_low) capture = 1'b1;
          else         bus_err_d = 1'b1;
        end
      end
      CAPTURED: begin
        if (changed) state_d = all_high ? IDLE : SETTLING;
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed mask is cleared on the pulse edge while still accepting a new digit.
  always_comb begin
    digits_d = digits_q;
    valid_d  = valid_q;
    gerr_d   = gerr_q;
    frame_d  = (mask_q == 4'hF);
    mask_d   = (mask_q == 4'hF) ? 4'h0 : mask_q;
    if (capture) begin
      valid_d[cap_idx] = 1'b1;
      mask_d[cap_idx]  = 1'b1;
      gerr_d[cap_idx]  = !dec_hit;
      if (dec_hit) digits_d[{cap_idx, 2'b00} +: 4] = dec_nibble;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q   <= BUS_IDLE;
      sync2_q   <= BUS_IDLE;
      prev_q    <= BUS_IDLE;
      cnt_q     <= '0;
      state_q   <= IDLE;
      digits_q  <= 16'h0000;
      valid_q   <= 4'h0;
      gerr_q    <= 4'h0;
      mask_q    <= 4'h0;
      frame_q   <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      sync1_q   <= {AN, seven};
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      digits_q  <= digits_d;
      valid_q   <= valid_d;
      gerr_q    <= gerr_d;
      mask_q    <= mask_d;
      frame_q   <= frame_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign glyph_err   = gerr_q;
  assign frame_done  = frame_q;
  assign bus_err     = bus_err_q;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Scoreboard bench for seg7_scan_capture: expected word/valid/error snapshots are
// queued as each digit is driven and popped when the capture latency elapses.
module tb_seg7_scan_capture;
  import seg7_pkg::*;

  localparam int SETTLE = 4;
  localparam int LAT    = SETTLE + 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [6:0]  seven = SEG_IDLE;
  logic [3:0]  AN    = AN_IDLE;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic [3:0]  glyph_err;
  logic        frame_done;
  logic        bus_err;

  logic [6:0]  dec_seg = 7'h7F;
  logic [3:0]  dec_nib;
  logic        dec_hit;

  seg7_scan_capture #(.SETTLE(SETTLE), .CNT_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .seven       (seven),
    .AN          (AN),
    .digits      (digits),
    .digit_valid (digit_valid),
    .glyph_err   (glyph_err),
    .frame_done  (frame_done),
    .bus_err     (bus_err)
  );

  seg7_glyph_decode u_dec (
    .seg_i    (dec_seg),
    .nibble_o (dec_nib),
    .hit_o    (dec_hit)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] d;
    logic [3:0]  v;
    logic [3:0]  e;
  } snap_t;

  snap_t       sb_q[$];
  snap_t       got;
  logic [15:0] exp_d = 16'h0;
  logic [3:0]  exp_v = 4'h0;
  logic [3:0]  exp_e = 4'h0;
  logic [3:0]  exp_m = 4'h0;
  int          exp_frames = 0;
  int          tests_run = 0;
  int          tests_failed = 0;
  int          frame_cnt = 0;
  int          bus_cnt = 0;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always @(negedge clock) begin
    if (frame_done) frame_cnt++;
    if (bus_err)    bus_cnt++;
  end

  task automatic step(input int n);
    repeat (n) @(negedge clock);
    #1;
  endtask

  task automatic push_snapshot();
    snap_t s;
    s.d = exp_d;
    s.v = exp_v;
    s.e = exp_e;
    sb_q.push_back(s);
  endtask

  task automatic model_capture(input logic [3:0] an, input logic [6:0] seg);
    int idx;
    int hitn;
    idx  = 0;
    hitn = -1;
    for (int i = 3; i >= 0; i--) if (!an[i]) idx = i;
    for (int g = 0; g < 16; g++) if (glyph_tab[g] == seg) hitn = g;
    exp_v[idx] = 1'b1;
    exp_m[idx] = 1'b1;
    if (hitn >= 0) begin
      exp_d[idx*4 +: 4] = 4'(hitn);
      exp_e[idx]        = 1'b0;
    end else begin
      exp_e[idx] = 1'b1;
    end
    if (exp_m == 4'hF) begin
      exp_m = 4'h0;
      exp_frames++;
    end
    push_snapshot();
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input bit capt);
    AN    = an;
    seven = seg;
    if (capt) model_capture(an, seg);
  endtask

  task automatic model_reset();
    exp_d = 16'h0;
    exp_v = 4'h0;
    exp_e = 4'h0;
    exp_m = 4'h0;
    sb_q.delete();
  endtask

  task automatic test_decode();
    for (int g = 0; g < 16; g++) begin
      dec_seg = glyph_tab[g];
      #1;
      tests_run++;
      if (dec_hit !== 1'b1 || dec_nib !== 4'(g)) begin
        tests_failed++;
        $display("FAIL decode_%0d: got hit=%b nib=%h, want hit=1 nib=%h", g, dec_hit, dec_nib, 4'(g));
      end
    end
    dec_seg = 7'h55;
    #1;
    tests_run++;
    if (dec_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL decode_bad55: got hit=%b, want 0", dec_hit);
    end
    dec_seg = 7'h7F;
    #1;
    tests_run++;
    if (dec_hit !== 1'b0) begin
      tests_failed++;
      $display("FAIL decode_blank: got hit=%b, want 0", dec_hit);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(AN_IDLE, SEG_IDLE, 0);
    step(3);
    tests_run++;
    if ({digits, digit_valid, glyph_err, frame_done, bus_err} !== 26'h0) begin
      tests_failed++;
      $display("FAIL reset_hold: got d=%h v=%b e=%b fd=%b be=%b, want all 0",
               digits, digit_valid, glyph_err, frame_done, bus_err);
    end
    reset = 1'b1;
    step(100);
    push_snapshot();
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e} || frame_cnt !== 0 || bus_cnt !== 0) begin
      tests_failed++;
      $display("FAIL reset_idle: got d=%h v=%b e=%b frames=%0d buserrs=%0d, want d=%h v=%b e=%b 0 0",
               digits, digit_valid, glyph_err, frame_cnt, bus_cnt, got.d, got.v, got.e);
    end
  endtask

  task automatic test_latency();
    drive(4'hE, 7'h30, 1);
    step(LAT - 1);
    tests_run++;
    if (digit_valid !== 4'h0 || digits !== 16'h0000) begin
      tests_failed++;
      $display("FAIL latency_early: got d=%h v=%b, want 0000 0000", digits, digit_valid);
    end
    step(1);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL latency_capture: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(4);
    tests_run++;
    if (digits !== 16'h0003 || digit_valid !== 4'b0001 || frame_cnt !== exp_frames) begin
      tests_failed++;
      $display("FAIL latency_hold: got d=%h v=%b frames=%0d, want 0003 0001 %0d",
               digits, digit_valid, frame_cnt, exp_frames);
    end
    drive(AN_IDLE, SEG_IDLE, 0);
    step(8);
  endtask

  task automatic test_scan();
    logic [3:0] ans  [4] = '{4'hE, 4'hD, 4'hB, 4'h7};
    logic [6:0] segs [4] = '{7'h02, 7'h08, 7'h46, 7'h0E};
    for (int i = 0; i < 4; i++) begin
      drive(ans[i], segs[i], 1);
      step(LAT);
      got = sb_q.pop_front();
      tests_run++;
      if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e} || frame_done !== 1'b0) begin
        tests_failed++;
        $display("FAIL scan_digit%0d: got d=%h v=%b e=%b fd=%b, want d=%h v=%b e=%b fd=0",
                 i, digits, digit_valid, glyph_err, frame_done, got.d, got.v, got.e);
      end
      step(1);
      if (i == 3) begin
        tests_run++;
        if (frame_done !== 1'b1) begin
          tests_failed++;
          $display("FAIL scan_frame_pulse: got frame_done=%b, want 1", frame_done);
        end
      end
      step(1);
    end
    tests_run++;
    if (digits !== 16'hFCA6 || frame_done !== 1'b0 || frame_cnt !== exp_frames) begin
      tests_failed++;
      $display("FAIL scan_word: got d=%h fd=%b frames=%0d, want FCA6 0 %0d",
               digits, frame_done, frame_cnt, exp_frames);
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 10; k++) begin
      drive(4'hE, (k % 2 == 1) ? 7'h24 : 7'h30, 0);
      step(2);
    end
    push_snapshot();
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL glitch_nocap: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    drive(4'hE, 7'h30, 1);
    step(LAT);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL glitch_settled: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(2);
    drive(4'hE, 7'h55, 1);
    step(LAT);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL glyph_err: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(2);
    drive(4'hE, 7'h79, 1);
    step(LAT);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL glyph_recover: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(2);
  endtask

  task automatic test_bus_err();
    logic [3:0] ans  [3] = '{4'hB, 4'h7, 4'hD};
    logic [6:0] segs [3] = '{7'h19, 7'h12, 7'h78};
    int b0;
    b0 = bus_cnt;
    drive(4'hC, 7'h40, 0);
    step(LAT - 1);
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bus_err_early: got %b, want 0", bus_err);
    end
    step(1);
    tests_run++;
    if (bus_err !== 1'b1) begin
      tests_failed++;
      $display("FAIL bus_err_pulse: got %b, want 1", bus_err);
    end
    step(1);
    tests_run++;
    if (bus_err !== 1'b0) begin
      tests_failed++;
      $display("FAIL bus_err_end: got %b, want 0", bus_err);
    end
    step(7);
    push_snapshot();
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e} || bus_cnt !== b0 + 1) begin
      tests_failed++;
      $display("FAIL bus_err_state: got d=%h v=%b e=%b pulses=%0d, want d=%h v=%b e=%b pulses=%0d",
               digits, digit_valid, glyph_err, bus_cnt - b0, got.d, got.v, got.e, 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(ans[i], segs[i], 1);
      step(LAT);
      got = sb_q.pop_front();
      tests_run++;
      if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
        tests_failed++;
        $display("FAIL bus_mask_cap%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                 i, digits, digit_valid, glyph_err, got.d, got.v, got.e);
      end
      step(2);
      tests_run++;
      if (frame_cnt !== exp_frames) begin
        tests_failed++;
        $display("FAIL bus_mask_frame%0d: got frames=%0d, want %0d", i, frame_cnt, exp_frames);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [3:0] ans  [4] = '{4'h7, 4'hB, 4'hD, 4'hE};
    logic [6:0] segs [4] = '{7'h00, 7'h10, 7'h21, 7'h03};
    drive(4'hE, 7'h40, 1);
    step(LAT);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL pre_reset_cap0: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(2);
    drive(4'hD, 7'h79, 1);
    step(LAT);
    got = sb_q.pop_front();
    tests_run++;
    if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
      tests_failed++;
      $display("FAIL pre_reset_cap1: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
               digits, digit_valid, glyph_err, got.d, got.v, got.e);
    end
    step(2);
    drive(4'hB, 7'h24, 0);
    step(3);
    #1;
    reset = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({digits, digit_valid, glyph_err, frame_done, bus_err} !== 26'h0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got d=%h v=%b e=%b fd=%b be=%b, want all 0",
               digits, digit_valid, glyph_err, frame_done, bus_err);
    end
    drive(AN_IDLE, SEG_IDLE, 0);
    step(3);
    reset = 1'b1;
    step(5);
    for (int i = 0; i < 4; i++) begin
      drive(ans[i], segs[i], 1);
      step(LAT);
      got = sb_q.pop_front();
      tests_run++;
      if ({digits, digit_valid, glyph_err} !== {got.d, got.v, got.e}) begin
        tests_failed++;
        $display("FAIL post_reset_cap%0d: got d=%h v=%b e=%b, want d=%h v=%b e=%b",
                 i, digits, digit_valid, glyph_err, got.d, got.v, got.e);
      end
      step(1);
      tests_run++;
      if (frame_cnt !== exp_frames) begin
        tests_failed++;
        $display("FAIL post_reset_frame%0d: got frames=%0d, want %0d", i, frame_cnt, exp_frames);
      end
      step(1);
    end
  endtask

  initial begin
    test_decode();
    test_reset();
    test_latency();
    test_scan();
    test_glitch();
    test_bus_err();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
